// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: sequences one full_adder cell over the
// operands LSB first, holding the carry in a register between bits.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] s_shift;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts it lines up LSB first.
  if (WIDTH == 1) begin : g_w1
    assign s_shift = fa_s;
  end else begin : g_wn
    assign s_shift = {fa_s, s_sr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          sum_d   = s_shift;
          cout_d  = fa_co;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
// Results and completion cycles are queued at launch, checked on done.

module tb_serial_adder_ctrl;

  typedef struct {
    logic [8:0] s;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  int         cyc;
  int         n_chk;
  int         n_err;

  logic       start8, c8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1, c1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  exp_t       q8[$];
  exp_t       q1[$];
  exp_t       e8, e1;
  logic [8:0] last8;
  logic [1:0] last1;
  int         bcnt8, bcnt1;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .a_in    (a8),
    .b_in    (b8),
    .cin     (c8),
    .busy    (busy8),
    .done    (done8),
    .sum_out (sum8),
    .cout    (cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start1),
    .a_in    (a1),
    .b_in    (b1),
    .cin     (c1),
    .busy    (busy1),
    .done    (done1),
    .sum_out (sum1),
    .cout    (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; the accepting edge is the next posedge.
  task automatic go8(input logic [7:0] a, input logic [7:0] b,
                     input logic c);
    exp_t e;
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    c8 = c;
    @(negedge clk);
    start8 = 1'b0;
    a8 = $urandom;
    b8 = $urandom;
    c8 = 1'($urandom);
    e.s = {1'b0, a} + {1'b0, b} + 9'(c);
    e.cyc = cyc + 8;
    q8.push_back(e);
  endtask

  task automatic go1(input logic a, input logic b, input logic c);
    exp_t e;
    start1 = 1'b1;
    a1 = a;
    b1 = b;
    c1 = c;
    @(negedge clk);
    start1 = 1'b0;
    e.s = 9'(a) + 9'(b) + 9'(c);
    e.cyc = cyc + 1;
    q1.push_back(e);
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q8", 64'(q8.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last8 = '0;
      bcnt8 = 0;
    end else begin
      if (busy8) bcnt8++;
      if (done8) begin
        if (q8.size() == 0) begin
          chk("spurious_done8", 64'd1, 64'd0);
        end else begin
          e8 = q8.pop_front();
          chk("sum8", {cout8, sum8}, e8.s);
          chk("when8", 64'(cyc), 64'(e8.cyc));
          chk("busy_len8", 64'(bcnt8), 64'd8);
          last8 = e8.s;
        end
        bcnt8 = 0;
      end else begin
        chk("hold8", {cout8, sum8}, last8);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last1 = '0;
      bcnt1 = 0;
    end else begin
      if (busy1) bcnt1++;
      if (done1) begin
        if (q1.size() == 0) begin
          chk("spurious_done1", 64'd1, 64'd0);
        end else begin
          e1 = q1.pop_front();
          chk("sum1", {cout1, sum1}, e1.s);
          chk("when1", 64'(cyc), 64'(e1.cyc));
          chk("busy_len1", 64'(bcnt1), 64'd1);
          last1 = e1.s[1:0];
        end
        bcnt1 = 0;
      end else begin
        chk("hold1", {cout1, sum1}, last1);
      end
    end
  end

  initial begin
    int n;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    c8 = 1'b0;
    start1 = 1'b0;
    a1 = '0;
    b1 = '0;
    c1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_done8", done8, 1'b0);
    chk("rst_sum8", {cout8, sum8}, 9'd0);
    chk("rst_busy1", busy1, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    go8(8'h35, 8'h4A, 1'b0);
    drain(20);
    go8(8'hFF, 8'h01, 1'b0);
    drain(20);
    go8(8'hFF, 8'hFF, 1'b1);
    drain(20);

    // back-to-back: relaunch in the done cycle
    go8(8'h35, 8'h4A, 1'b0);
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", done8, 1'b1);
    go8(8'h10, 8'h20, 1'b0);
    chk("b2b_busy", busy8, 1'b1);
    drain(20);

    // start pulsed mid-run is ignored
    go8(8'h12, 8'h34, 1'b1);
    repeat (3) @(negedge clk);
    start8 = 1'b1;
    a8 = 8'hAA;
    b8 = 8'hCC;
    c8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain(20);
    repeat (3) @(negedge clk);

    // async reset in the 4th RUN cycle
    go8(8'h55, 8'h66, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy8", busy8, 1'b0);
    chk("arst_done8", done8, 1'b0);
    chk("arst_sum8", sum8, 8'h00);
    chk("arst_cout8", cout8, 1'b0);
    q8.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (14) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      go1(i[2], i[1], i[0]);
      repeat (2) @(negedge clk);
    end
    drain(10);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder built around the team's single-bit full_adder cell. It feeds the cell one operand bit per clock, LSB first, and holds the carry in a register between bits. It captures operands on a start pulse, runs WIDTH cycles and presents the registered sum and carry-out with a one-cycle done pulse. It sits directly upstream of full_adder as its sequencing stage, trading area for latency in multi-bit arithmetic paths.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk      input   1      rising-edge clock
rst_n    input   1      asynchronous active-low reset
start    input   1      request a new addition; sampled on rising clk
a_in     input   WIDTH  operand A; captured when start is accepted
b_in     input   WIDTH  operand B; captured when start is accepted
cin      input   1      carry-in; captured when start is accepted
busy     output  1      high while bits are being processed (RUN)
done     output  1      one-cycle pulse when a result is available
sum_out  output  WIDTH  registered result (a_in + b_in + cin) mod 2^WIDTH
cout     output  1      registered carry out of bit WIDTH-1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, sum_out=0, cout=0.
  - Working shift registers, carry register and bit counter are cleared.
  - Reset applies immediately, without waiting for clk.
- States:
  - IDLE: waiting for start.
  - RUN: processing bits; busy=1.
  - DONE: result just produced; done=1 for exactly this cycle.
- IDLE, start=1 at edge k:
  - a_sr<=a_in, b_sr<=b_in, carry<=cin, cnt<=0.
  - State goes to RUN.
- RUN, each edge:
  - full_adder is driven with a=a_sr[0], b=b_sr[0], cin=carry.
  - The sum bit is shifted into the MSB of the working result register s_sr (s_sr shifts right).
  - carry<=cout of the cell; a_sr and b_sr shift right; cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1: sum_out<=final s_sr value, cout<=final carry, state goes to DONE.
- Latency:
  - Bit processing occupies edges k+1..k+WIDTH.
  - done=1 during the cycle following edge k+WIDTH.
  - busy=1 from edge k until edge k+WIDTH, i.e. for WIDTH cycles.
- DONE:
  - With start=0 at the next edge, state goes to IDLE and done goes to 0.
  - With start=1 at that edge, the new operands are captured and state goes directly to RUN, giving back-to-back operation with no idle gap.
- start while in RUN is ignored. Operands are not re-captured and the running operation is unaffected.
- sum_out and cout change only at the completion edge. They hold their values through later IDLE and RUN periods until the next completion.
- a_in, b_in and cin are don't-care except at the accepting edge.
- WIDTH=1: a single RUN cycle, then DONE. busy is high for exactly one cycle.
- Overflow: the sum wraps modulo 2^WIDTH and the overflow appears only on cout. There is no saturation.
- Reset during RUN or DONE: the operation is aborted and no done pulse follows. sum_out and cout read 0 after reset.

Test Plan:
- WIDTH=8, reset, then start with a=0x35, b=0x4A, cin=0 -> busy high for 8 cycles; done pulses once; sum_out=0x7F, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum_out=0xFF, cout=1.
- Back-to-back: hold start=1 in the DONE cycle with a=0x10, b=0x20 -> next done exactly 9 cycles after the first; sum_out=0x30. The first result stays on sum_out until then.
- Pulse start mid-RUN with different operands -> ignored; the original result is produced at the original time.
- Assert rst_n=0 asynchronously at the 4th RUN cycle -> busy, done, sum_out and cout are 0 immediately; no done pulse after release.
- WIDTH=1, all 8 (a,b,cin) combinations -> sum_out/cout match the full-adder truth table; each done pulse comes 1 cycle after the start edge (busy high for 1 cycle).
